// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : led_matrix_pkg
//  Description : Shared defaults, receiver state encoding and checksum width
//                for the LED-matrix serial frame receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_matrix_pkg;

    // Payload length in bits; must stay a multiple of 8.
    localparam int NLEDS_DEFAULT = 64;

    // Preamble that marks the start of a frame.
    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Width of the XOR checksum trailer.
    localparam int CSUM_W = 8;

    // Receiver state machine encoding.
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        CSUM = 2'd2
    } rx_state_t;

endpackage : led_matrix_pkg
`default_nettype wire

// File: rtl/frame_csum_acc.sv
`default_nettype none
// ============================================================================
//  Module      : frame_csum_acc
//  Description : Assembles serial payload bits into bytes (first bit = byte
//                MSB) and XORs every completed byte into a running checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_csum_acc
    import led_matrix_pkg::*;
(
    input  logic              dclk,
    input  logic              reset,
    input  logic              clear,
    input  logic              bit_valid,
    input  logic              din,
    output logic [CSUM_W-1:0] csum
);

    // Only the first seven bits of a byte are stored; the eighth arrives on
    // din and completes the byte in the same cycle it is folded in.
    logic [CSUM_W-2:0] byte_q, byte_d;
    logic [2:0]        cnt_q,  cnt_d;
    logic [CSUM_W-1:0] csum_q, csum_d;
    logic [CSUM_W-1:0] full_byte;

    assign full_byte = {byte_q, din};
    assign csum      = csum_q;

    // Next-state: clear wins over accumulation; fold on the eighth bit.
    always_comb begin
        byte_d = byte_q;
        cnt_d  = cnt_q;
        csum_d = csum_q;
        if (clear) begin
            byte_d = '0;
            cnt_d  = '0;
            csum_d = '0;
        end else if (bit_valid) begin
            byte_d = full_byte[CSUM_W-2:0];
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                csum_d = csum_q ^ full_byte;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge dclk) begin
        if (reset) begin
            byte_q <= '0;
            cnt_q  <= '0;
            csum_q <= '0;
        end else begin
            byte_q <= byte_d;
            cnt_q  <= cnt_d;
            csum_q <= csum_d;
        end
    end

endmodule : frame_csum_acc
`default_nettype wire

// File: rtl/frame_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : frame_rx_checker
//  Description : Serial frame receiver. Hunts for a sync word, shifts in an
//                NLEDS-bit payload and an 8-bit XOR checksum, and publishes
//                the payload only when the checksum matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_rx_checker
    import led_matrix_pkg::*;
#(
    parameter int         NLEDS     = NLEDS_DEFAULT,
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
)(
    input  logic             dclk,
    input  logic             reset,
    input  logic             din,
    output logic [NLEDS-1:0] frame_out,
    output logic             frame_valid,
    output logic             csum_err,
    output logic [7:0]       err_count,
    output logic             busy
);

    localparam int CNT_W = $clog2(NLEDS);

    rx_state_t         state_q, state_d;
    // Seven stored hunt bits plus the live din bit form the 8-bit window.
    logic [6:0]        hunt_q, hunt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [NLEDS-1:0]  payload_q, payload_d;
    logic [CSUM_W-2:0] rx_csum_q, rx_csum_d;
    logic [NLEDS-1:0]  frame_out_q, frame_out_d;
    logic              frame_valid_q, frame_valid_d;
    logic              csum_err_q, csum_err_d;
    logic [7:0]        err_count_q, err_count_d;

    logic              acc_clear;
    logic              acc_bit_valid;
    logic [CSUM_W-1:0] calc_csum;
    logic [7:0]        hunt_window;
    logic [CSUM_W-1:0] rx_csum_full;

    assign hunt_window  = {hunt_q, din};
    assign rx_csum_full = {rx_csum_q, din};

    frame_csum_acc u_csum_acc (
        .dclk      (dclk),
        .reset     (reset),
        .clear     (acc_clear),
        .bit_valid (acc_bit_valid),
        .din       (din),
        .csum      (calc_csum)
    );

    // FSM next-state, shift registers and output pulse generation.
    always_comb begin
        state_d       = state_q;
        hunt_d        = hunt_q;
        bit_cnt_d     = bit_cnt_q;
        payload_d     = payload_q;
        rx_csum_d     = rx_csum_q;
        frame_out_d   = frame_out_q;
        frame_valid_d = 1'b0;
        csum_err_d    = 1'b0;
        err_count_d   = err_count_q;
        acc_clear     = 1'b0;
        acc_bit_valid = 1'b0;

        case (state_q)
            HUNT: begin
                hunt_d = hunt_window[6:0];
                if (hunt_window == SYNC_WORD) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    acc_clear = 1'b1;
                end
            end
            DATA: begin
                acc_bit_valid = 1'b1;
                payload_d     = {payload_q[NLEDS-2:0], din};
                if (bit_cnt_q == CNT_W'(NLEDS - 1)) begin
                    state_d   = CSUM;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            CSUM: begin
                rx_csum_d = rx_csum_full[CSUM_W-2:0];
                if (bit_cnt_q == CNT_W'(CSUM_W - 1)) begin
                    if (rx_csum_full == calc_csum) begin
                        frame_out_d   = payload_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        csum_err_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                    // Cleared hunt window: a sync cannot straddle the trailer.
                    state_d   = HUNT;
                    hunt_d    = '0;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = HUNT;
                hunt_d  = '0;
            end
        endcase
    end

    // State and output registers; reset has priority over everything.
    always_ff @(posedge dclk) begin
        if (reset) begin
            state_q       <= HUNT;
            hunt_q        <= '0;
            bit_cnt_q     <= '0;
            payload_q     <= '0;
            rx_csum_q     <= '0;
            frame_out_q   <= '0;
            frame_valid_q <= 1'b0;
            csum_err_q    <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            hunt_q        <= hunt_d;
            bit_cnt_q     <= bit_cnt_d;
            payload_q     <= payload_d;
            rx_csum_q     <= rx_csum_d;
            frame_out_q   <= frame_out_d;
            frame_valid_q <= frame_valid_d;
            csum_err_q    <= csum_err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign frame_out   = frame_out_q;
    assign frame_valid = frame_valid_q;
    assign csum_err    = csum_err_q;
    assign err_count   = err_count_q;
    assign busy        = (state_q == DATA) || (state_q == CSUM);

endmodule : frame_rx_checker
`default_nettype wire

// File: tb/tb_frame_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_rx_checker
//  Description : Directed self-checking bench for frame_rx_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_rx_checker;

    logic        dclk;
    logic        reset;
    logic        din;
    logic [63:0] frame_out;
    logic        frame_valid;
    logic        csum_err;
    logic [7:0]  err_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Pulse monitor state
    int cyc       = 0;
    int fv_cnt    = 0;
    int ce_cnt    = 0;
    int fv_last   = 0;
    int fv_prev   = 0;

    frame_rx_checker #(
        .NLEDS     (64),
        .SYNC_WORD (8'hA5)
    ) dut (
        .dclk        (dclk),
        .reset       (reset),
        .din         (din),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .csum_err    (csum_err),
        .err_count   (err_count),
        .busy        (busy)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // Cycle counter on the active edge.
    always @(posedge dclk) cyc <= cyc + 1;

    // Pulse counters, sampled on the opposite edge.
    always @(negedge dclk) begin
        if (frame_valid) begin
            fv_cnt  <= fv_cnt + 1;
            fv_prev <= fv_last;
            fv_last <= cyc;
        end
        if (csum_err) begin
            ce_cnt <= ce_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge dclk);
        din = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_payload(input logic [63:0] p);
        for (int i = 63; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic send_frame(input logic [63:0] p, input logic [7:0] cs);
        send_byte(8'hA5);
        send_payload(p);
        send_byte(cs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    int fv0, ce0;

    initial begin
        reset = 1'b1;
        din   = 1'b0;
        repeat (3) @(negedge dclk);
        reset = 1'b0;

        // Reset state
        check("rst_frame_out", frame_out, 64'h0);
        check("rst_frame_valid", {63'h0, frame_valid}, 64'h0);
        check("rst_csum_err", {63'h0, csum_err}, 64'h0);
        check("rst_err_count", {56'h0, err_count}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);

        // Clean frame, with busy checked around the frame boundaries
        fv0 = fv_cnt; ce0 = ce_cnt;
        send_byte(8'hA5);
        check("busy_pre_sync", {63'h0, busy}, 64'h0);
        send_bit(1'b0);                         // payload MSB of 0x01
        check("busy_after_sync", {63'h0, busy}, 64'h1);
        for (int i = 62; i >= 0; i--) send_bit((i == 56) ? 1'b1 : 1'b0);
        send_byte(8'h01);
        check("busy_last_csum_bit", {63'h0, busy}, 64'h1);
        send_bit(1'b0);
        check("busy_after_frame", {63'h0, busy}, 64'h0);
        check("clean_fv_level", {63'h0, frame_valid}, 64'h1);
        idle(3);
        check("clean_fv_pulses", 64'(fv_cnt - fv0), 64'd1);
        check("clean_ce_pulses", 64'(ce_cnt - ce0), 64'd0);
        check("clean_frame_out", frame_out, 64'h0100_0000_0000_0000);
        check("clean_err_count", {56'h0, err_count}, 64'd0);

        // Bad checksum: correct value for all-FF payload is 0x00
        fv0 = fv_cnt; ce0 = ce_cnt;
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
        send_bit(1'b0);
        check("bad_ce_level", {63'h0, csum_err}, 64'h1);
        idle(3);
        check("bad_ce_pulses", 64'(ce_cnt - ce0), 64'd1);
        check("bad_fv_pulses", 64'(fv_cnt - fv0), 64'd0);
        check("bad_err_count", {56'h0, err_count}, 64'd1);
        check("bad_frame_out_kept", frame_out, 64'h0100_0000_0000_0000);

        // 37 noise bits of repeating 1100 (no A5 window, no early overlap)
        fv0 = fv_cnt; ce0 = ce_cnt;
        for (int i = 0; i < 37; i++) send_bit((i % 4) < 2);
        send_frame(64'hF0F0_F0F0_F0F0_F0F0, 8'h00);
        idle(3);
        check("noise_fv_pulses", 64'(fv_cnt - fv0), 64'd1);
        check("noise_ce_pulses", 64'(ce_cnt - ce0), 64'd0);
        check("noise_frame_out", frame_out, 64'hF0F0_F0F0_F0F0_F0F0);

        // Reset after 30 payload bits
        fv0 = fv_cnt; ce0 = ce_cnt;
        send_byte(8'hA5);
        for (int i = 0; i < 30; i++) send_bit(i[0]);
        @(negedge dclk);
        reset = 1'b1;
        din   = 1'b0;
        repeat (2) @(negedge dclk);
        reset = 1'b0;
        check("midrst_err_count", {56'h0, err_count}, 64'd0);
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_frame_out", frame_out, 64'h0);
        check("midrst_no_pulse", 64'((fv_cnt - fv0) + (ce_cnt - ce0)), 64'd0);
        send_frame(64'h1234_5678_9ABC_DEF0, 8'h00);
        idle(3);
        check("midrst_fv_pulses", 64'(fv_cnt - fv0), 64'd1);
        check("midrst_frame_out_new", frame_out, 64'h1234_5678_9ABC_DEF0);

        // Back-to-back frames, zero idle bits between them
        fv0 = fv_cnt; ce0 = ce_cnt;
        send_frame(64'h0102_0408_1020_4080, 8'hFF);
        send_frame(64'hAA55_AA55_AA55_AA55, 8'h00);
        idle(3);
        check("b2b_fv_pulses", 64'(fv_cnt - fv0), 64'd2);
        check("b2b_spacing", 64'(fv_last - fv_prev), 64'd80);
        check("b2b_ce_pulses", 64'(ce_cnt - ce0), 64'd0);
        check("b2b_frame_out", frame_out, 64'hAA55_AA55_AA55_AA55);

        // Error saturation: 260 bad frames, counter stops at 255
        fv0 = fv_cnt; ce0 = ce_cnt;
        for (int k = 0; k < 254; k++) send_frame(64'h0, 8'h01);
        idle(3);
        check("sat_err_254", {56'h0, err_count}, 64'd254);
        for (int k = 0; k < 6; k++) send_frame(64'h0, 8'h01);
        idle(3);
        check("sat_err_255", {56'h0, err_count}, 64'd255);
        check("sat_ce_pulses", 64'(ce_cnt - ce0), 64'd260);
        check("sat_fv_pulses", 64'(fv_cnt - fv0), 64'd0);
        check("sat_frame_out_kept", frame_out, 64'hAA55_AA55_AA55_AA55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_frame_rx_checker
`default_nettype wire
